// File: rtl/jpeg_bitpacker.sv
// Packs right-aligned variable-length Huffman codes MSB-first into a byte stream,
// inserting a 0x00 after every 0xFF and padding with 1s on flush.
module jpeg_bitpacker #(
    parameter int unsigned CODE_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  code_valid,
    output logic                  code_ready,
    input  logic [CODE_WIDTH-1:0] code_data,
    input  logic [4:0]            code_len,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_byte,
    output logic                  flush_done,
    output logic                  busy
);

    localparam int unsigned CntW = $clog2(ACC_WIDTH + 1);
    localparam logic [CntW-1:0] AccBits  = CntW'(ACC_WIDTH);
    localparam logic [CntW-1:0] ReadyMax = CntW'(ACC_WIDTH - CODE_WIDTH);
    localparam logic [CntW-1:0] ByteBits = CntW'(8);

    typedef enum logic [1:0] {StRun, StPad, StDrain, StDone} state_e;

    state_e                state_q, state_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                  stuff_q, stuff_d;
    logic                  out_valid_q, out_valid_d;
    logic [7:0]            out_byte_q, out_byte_d;

    logic                  slot_free;
    logic                  emit;
    logic                  accept;
    logic [ACC_WIDTH-1:0]  acc_sh;
    logic [CntW-1:0]       cnt_sh;
    logic [CntW-1:0]       code_len_eff;
    logic [CODE_WIDTH-1:0] code_mask;
    logic [CntW-1:0]       pad_len;
    logic [7:0]            pad_field;
    logic [ACC_WIDTH-1:0]  app_val;
    logic [CntW-1:0]       app_len;
    logic [CntW-1:0]       app_shift;

    assign code_ready = (state_q == StRun) && (bit_cnt_q <= ReadyMax) && reset_n;
    assign accept     = code_valid && code_ready;
    assign out_valid  = out_valid_q;
    assign out_byte   = out_byte_q;
    assign flush_done = (state_q == StDone);
    assign busy       = (state_q != StRun) || (bit_cnt_q != '0) || out_valid_q || stuff_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= StRun;
            acc_q       <= '0;
            bit_cnt_q   <= '0;
            stuff_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_byte_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            bit_cnt_q   <= bit_cnt_d;
            stuff_q     <= stuff_d;
            out_valid_q <= out_valid_d;
            out_byte_q  <= out_byte_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        stuff_d     = stuff_q;
        out_valid_d = out_valid_q;
        out_byte_d  = out_byte_q;
        emit        = 1'b0;
        slot_free   = !out_valid_q || out_ready;

        // Stuff byte wins over fresh data so 0xFF is always followed by 0x00.
        if (slot_free) begin
            if (stuff_q) begin
                out_byte_d  = 8'h00;
                out_valid_d = 1'b1;
                stuff_d     = 1'b0;
            end else if (bit_cnt_q >= ByteBits) begin
                emit        = 1'b1;
                out_byte_d  = acc_q[ACC_WIDTH-1 -: 8];
                out_valid_d = 1'b1;
                stuff_d     = (acc_q[ACC_WIDTH-1 -: 8] == 8'hFF);
            end else begin
                out_valid_d = 1'b0;
            end
        end

        acc_sh = emit ? (acc_q << 8) : acc_q;
        cnt_sh = emit ? (bit_cnt_q - ByteBits) : bit_cnt_q;

        if (int'(code_len) > CODE_WIDTH) begin
            code_len_eff = CntW'(CODE_WIDTH);
        end else begin
            code_len_eff = CntW'(code_len);
        end
        for (int i = 0; i < CODE_WIDTH; i++) begin
            code_mask[i] = (i < int'(code_len_eff));
        end

        pad_len = (cnt_sh[2:0] == 3'd0) ? '0 : CntW'(4'd8 - {1'b0, cnt_sh[2:0]});
        for (int i = 0; i < 8; i++) begin
            pad_field[i] = (i < int'(pad_len));
        end

        app_val = '0;
        app_len = '0;
        if (state_q == StRun && accept) begin
            app_val = ACC_WIDTH'(code_data & code_mask);
            app_len = code_len_eff;
        end else if (state_q == StPad) begin
            app_val = ACC_WIDTH'(pad_field);
            app_len = pad_len;
        end

        // New bits land directly below the bits surviving this cycle's emit.
        app_shift = AccBits - cnt_sh - app_len;
        acc_d     = acc_sh | (app_val << app_shift);
        bit_cnt_d = cnt_sh + app_len;

        case (state_q)
            StRun: begin
                if (flush) state_d = StPad;
            end
            StPad: begin
                state_d = StDrain;
            end
            StDrain: begin
                if (bit_cnt_q == '0 && !stuff_q && slot_free) state_d = StDone;
            end
            StDone: begin
                acc_d     = '0;
                bit_cnt_d = '0;
                state_d   = StRun;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

endmodule

// File: doc/jpeg_bitpacker.md
Name: jpeg_bitpacker

Overview:
- Sits directly downstream of the Huffman encode controller output of the JPEG encoder.
- Consumes variable-length, right-aligned Huffman/amplitude codes (up to 16 bits) and packs them MSB-first into a continuous byte stream.
- Inserts the JPEG 0x00 stuff byte after every emitted 0xFF.
- On flush, pads the final partial byte with 1s, drains all pending bytes, then signals completion. The result is entropy-coded segment bytes ready for marker/file assembly.

Parameters:
- CODE_WIDTH, 16: maximum code length in bits; width of code_data.
- ACC_WIDTH, 32: bit-accumulator width; must be at least 2*CODE_WIDTH.

Ports:
- clock  in  1  single clock; all logic rising-edge.
- reset_n  in  1  synchronous, active-low reset.
- code_valid  in  1  code_data/code_len are valid this cycle.
- code_ready  out  1  block accepts a code this cycle; a code is accepted when code_valid && code_ready.
- code_data  in  CODE_WIDTH  code, right-aligned; bit [code_len-1] is sent first; bits at or above code_len are ignored.
- code_len  in  5  number of valid bits, 0..16; 0 is accepted as a no-op; values >16 are treated as 16.
- flush  in  1  end-of-scan request, sampled only in RUN.
- out_valid  out  1  out_byte is valid.
- out_ready  in  1  downstream takes the byte when out_valid && out_ready.
- out_byte  out  8  packed/stuffed output byte.
- flush_done  out  1  one-cycle pulse when the flush completes.
- busy  out  1  high when state != RUN or bit_cnt != 0 or out_valid or stuff_pending.

Behaviour:
- Reset (reset_n low at a clock edge):
  - acc=0, bit_cnt=0, stuff_pending=0, state=RUN, out_valid=0, out_byte=0x00, flush_done=0.
  - code_ready is forced 0 while reset_n is low.
  - Reset mid-operation discards all partial bits and pending bytes; no further bytes are emitted.
- Accumulator:
  - acc holds bit_cnt valid bits, MSB-aligned at acc[ACC_WIDTH-1].
  - bit_cnt is 6 bits, range 0..32.
- code_ready = (state==RUN) && (bit_cnt <= ACC_WIDTH-CODE_WIDTH) && reset_n.
- Output register update:
  - out_byte/out_valid may load only when the slot is free: (!out_valid || out_ready).
  - Load priority:
    1. If stuff_pending, load 0x00 and clear stuff_pending.
    2. Else if bit_cnt >= 8, load acc[top 8]; shift acc left by 8; bit_cnt -= 8; if the loaded byte is 0xFF, set stuff_pending.
    3. Else, out_valid <= 0 (if the slot was freed).
  - While out_valid && !out_ready, out_byte is held stable.
- Append, same cycle as an emit:
  - The emit shift is applied first.
  - The accepted code is then OR-ed in at position (post-shift bit_cnt), i.e. left-shifted by ACC_WIDTH - bit_cnt' - len.
  - bit_cnt_next = bit_cnt - (emit?8:0) + len.
  - No bits may be lost or reordered under any combination of accept, emit and backpressure.
- Latency: a code accepted in cycle N that completes a byte (bit_cnt was 0, len 8) gives out_valid=1 in cycle N+2 with out_ready high. Throughput is 1 byte/cycle sustained.
- State machine:
  - RUN: normal operation.
    - If flush=1, go to PAD.
    - A code accepted in the same cycle as flush is included before padding.
  - PAD: one cycle; code_ready=0.
    - If bit_cnt%8 != 0, set the next (8 - bit_cnt%8) bits to 1 and round bit_cnt up to a multiple of 8.
    - Then go to DRAIN. Padding that yields 0xFF is stuffed normally.
  - DRAIN: code_ready=0; emission continues.
    - When bit_cnt==0, !stuff_pending, and (!out_valid, or out_valid && out_ready this cycle), go to DONE.
  - DONE: one cycle; flush_done=1; acc=0; go to RUN.
- flush asserted outside RUN is ignored.
- flush with an empty accumulator goes RUN→PAD→DRAIN→DONE with no bytes emitted and flush_done still pulsed.

Test Plan:
1. Stuffing: accept (0xFF,len8) then (0xAB,len8), out_ready=1 → bytes 0xFF, 0x00, 0xAB in order, then out_valid=0.
2. Packing: accept (3'b101,len3) then (5'b10011,len5) → single byte 0xB3. Accept (0x1234,len16) → 0x12, 0x34. Accept (len0) → no byte, bit_cnt unchanged.
3. Flush pad: accept (3'b101,len3), then flush=1 → byte 0xBF, then flush_done pulses exactly once, 1 cycle, after the byte handshake; busy=0 afterwards.
4. Pad produces 0xFF: accept (4'b1111,len4), flush → bytes 0xFF, 0x00, then flush_done.
5. Backpressure: out_ready=0 for 12 cycles while code_valid=1 with len16 codes → code_ready deasserts once bit_cnt>16. Release out_ready → full byte stream matches the reference bit concatenation exactly; out_byte is stable while stalled.
6. Reset mid-stream: drop reset_n for 1 cycle with bit_cnt=13 and out_valid=1 → next cycle out_valid=0, busy=0, and a subsequent (0xA5,len8) produces exactly 0xA5.
